// File: rtl/sn74ls195a_shift_register.sv
// SN74LS195A 4-bit parallel-access shift register: synchronous load or J/K-bar
// shift toward Q[3], asynchronous active-low master reset, complemented last stage.
module sn74ls195a_shift_register (
  input  logic       CP,
  input  logic       MR,
  input  logic [3:0] P,
  input  logic       PE,
  input  logic       J,
  input  logic       K,
  output logic [3:0] Q,
  output logic       Q3not
);

  logic [3:0] q_q;
  logic [3:0] q_d;
  logic       first_d;

  // First stage follows the part's J/K-bar rule: 00 reset, 11 set, 01 hold, 10 toggle.
  always_comb begin
    first_d = (J & ~q_q[0]) | (K & q_q[0]);
    q_d     = q_q;
    if (!PE) begin
      q_d = P;
    end else begin
      q_d = {q_q[2:0], first_d};
    end
  end

  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q     = q_q;
  assign Q3not = ~q_q[3];

endmodule

// File: tb/tb_sn74ls195a_shift_register.sv
// Directed bench for sn74ls195a_shift_register: vector table for load/shift modes
// plus hand-written sequences for asynchronous reset and between-edge behaviour.
module tb_sn74ls195a_shift_register;

  logic       CP;
  logic       MR;
  logic [3:0] P;
  logic       PE;
  logic       J;
  logic       K;
  logic [3:0] Q;
  logic       Q3not;

  int unsigned n_checks;
  int unsigned n_fails;

  typedef struct {
    string      name;
    logic       pe;
    logic       j;
    logic       k;
    logic [3:0] p;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[$];

  sn74ls195a_shift_register dut (
    .CP    (CP),
    .MR    (MR),
    .P     (P),
    .PE    (PE),
    .J     (J),
    .K     (K),
    .Q     (Q),
    .Q3not (Q3not)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic check(input string name, input logic [3:0] exp_q, input logic exp_n);
    n_checks++;
    if (Q !== exp_q) begin
      n_fails++;
      $display("FAIL %s: Q got %b expected %b at %0t", name, Q, exp_q, $time);
    end
    n_checks++;
    if (Q3not !== exp_n) begin
      n_fails++;
      $display("FAIL %s: Q3not got %b expected %b at %0t", name, Q3not, exp_n, $time);
    end
  endtask

  task automatic add(input string name, input logic pe, input logic j, input logic k,
                     input logic [3:0] p, input logic [3:0] exp_q);
    vec_t v;
    v.name = name; v.pe = pe; v.j = j; v.k = k; v.p = p; v.exp_q = exp_q;
    vecs.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    add("load_a",    1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010);
    add("load_b",    1'b0, 1'b1, 1'b0, 4'b1010, 4'b1010);
    add("set",       1'b1, 1'b1, 1'b1, 4'b0000, 4'b0101);
    add("reset_1",   1'b1, 1'b0, 1'b0, 4'b1111, 4'b1010);
    add("reset_2",   1'b1, 1'b0, 1'b0, 4'b1111, 4'b0100);
    add("toggle_1",  1'b1, 1'b1, 1'b0, 4'b0000, 4'b1001);
    add("toggle_2",  1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010);
    add("toggle_3",  1'b1, 1'b1, 1'b0, 4'b0000, 4'b0101);
    add("hold_1",    1'b1, 1'b0, 1'b1, 4'b0000, 4'b1011);
    add("hold_2",    1'b1, 1'b0, 1'b1, 4'b0000, 4'b0111);
    add("hold_3",    1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111);
    add("hold_4",    1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111);
    add("load_jk_ig",1'b0, 1'b1, 1'b1, 4'b0110, 4'b0110);
    add("load_p_map",1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001);
    add("shift_p_ig",1'b1, 1'b0, 1'b0, 4'b1111, 4'b0010);

    // Reset held across two rising edges with a pending load.
    MR = 1'b0; PE = 1'b0; P = 4'b1010; J = 1'b0; K = 1'b0;
    #1;
    check("reset_async", 4'b0000, 1'b1);
    @(negedge CP);
    check("reset_edge5", 4'b0000, 1'b1);
    @(negedge CP);
    check("reset_edge15", 4'b0000, 1'b1);
    MR = 1'b1;
    #2;
    check("mr_release_noop", 4'b0000, 1'b1);

    foreach (vecs[i]) begin
      @(negedge CP);
      PE = vecs[i].pe; J = vecs[i].j; K = vecs[i].k; P = vecs[i].p;
      @(posedge CP);
      #1;
      check(vecs[i].name, vecs[i].exp_q, ~vecs[i].exp_q[3]);
    end

    // Between-edge input changes and the falling edge must not disturb Q (0010).
    PE = 1'b0; P = 4'b1101;
    @(negedge CP);
    #1;
    check("between_edges", 4'b0010, 1'b1);
    @(posedge CP);
    #1;
    check("load_after_change", 4'b1101, 1'b0);

    // Mid-cycle asynchronous reset, then edges ignored while MR is low.
    #2;
    MR = 1'b0;
    #1;
    check("mr_mid_cycle", 4'b0000, 1'b1);
    PE = 1'b0; P = 4'b1111;
    @(posedge CP);
    #1;
    check("mr_low_edge", 4'b0000, 1'b1);
    #2;
    MR = 1'b1;
    #1;
    check("mr_rise_mid", 4'b0000, 1'b1);
    @(posedge CP);
    #1;
    check("first_edge_after_mr", 4'b1111, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: simulation exceeded 5000 ns");
    $fatal(1, "timeout");
  end

endmodule
